// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 access
// encodings, the responder FSM state type and a size-decode helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACC0,
    ACC1,
    RESP
  } state_t;

  // Number of bytes touched by an access; 0 marks an encoding with no size.
  function automatic logic [2:0] sizeBytes(input logic [2:0] funct3);
    case (funct3)
      3'b000, 3'b100: return 3'd1;
      3'b001, 3'b101: return 3'd2;
      3'b010:         return 3'd4;
      default:        return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Word-organised single-port SRAM with per-byte write enables and a
// registered read port. Contents are deliberately not reset.
module dmem_sram_bank #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // One access per enabled cycle: enabled lanes are written, and the old word is read out.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (i_we[lane]) begin
          r_mem[i_addr][lane*8 +: 8] <= i_wdata[lane*8 +: 8];
        end
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core load/store path. Accepts one request at a time,
// inserts wait states, splits word-crossing accesses into two SRAM beats and
// returns extended load data with an error flag as a one-cycle pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1,
  parameter int MISALIGN_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [2:0]  i_req_funct3,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
  localparam logic [2:0]  WAIT_LAST = 3'(WAIT_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_funct3;
  logic          r_write;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic          r_split;
  logic [2:0]    r_waitCnt;
  logic [31:0]   r_beat0;

  logic [2:0]    w_inSize;
  logic          w_inBadF3;
  logic [32:0]   w_inEnd;
  logic          w_inCross;
  logic          w_inErr;
  logic          w_accept;

  logic [2:0]    w_size;
  logic [3:0]    w_sizeMask;
  logic [7:0]    w_mask8;
  logic [31:0]   w_wdataRot;
  logic          w_sramEn;
  logic [3:0]    w_sramWe;
  logic [AW-1:0] w_sramAddr;
  logic [31:0]   w_sramRdata;
  logic [31:0]   w_lo;
  logic [31:0]   w_raw;
  logic [31:0]   w_ext;

  assign w_accept = (r_state == IDLE) && i_req_valid;

  // Classify the incoming request on the cycle it is offered.
  always_comb begin
    w_inSize  = sizeBytes(i_req_funct3);
    w_inBadF3 = i_req_write ? (i_req_funct3 > F3_W)
                            : !(i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    w_inEnd   = {1'b0, i_req_addr} + 33'(w_inSize) - 33'd1;
    w_inCross = ({2'b00, i_req_addr[1:0]} + {1'b0, w_inSize}) > 4'd4;
    w_inErr   = w_inBadF3 || (w_inEnd >= LIMIT) || (w_inCross && (MISALIGN_EN == 0));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state selection; errors skip straight to the response.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (w_inErr)               w_next = RESP;
          else if (WAIT_CYCLES == 0) w_next = ACC0;
          else                       w_next = WAIT;
        end
      end
      WAIT:    if (r_waitCnt == WAIT_LAST) w_next = ACC0;
      ACC0:    w_next = r_split ? ACC1 : RESP;
      ACC1:    w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture the request at accept; later input activity is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_split  <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= i_req_addr[AW+1:0];
      r_funct3 <= i_req_funct3;
      r_write  <= i_req_write;
      r_wdata  <= i_req_wdata;
      r_err    <= w_inErr;
      r_split  <= w_inCross && !w_inErr;
    end
  end

  // Wait-state counter, active only while in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     r_waitCnt <= '0;
    else if (r_state != WAIT)       r_waitCnt <= '0;
    else if (r_waitCnt == WAIT_LAST) r_waitCnt <= '0;
    else                            r_waitCnt <= r_waitCnt + 3'd1;
  end

  // Lane mask over two words and store data rotated into lane position.
  always_comb begin
    w_size = sizeBytes(r_funct3);
    case (w_size)
      3'd1:    w_sizeMask = 4'b0001;
      3'd2:    w_sizeMask = 4'b0011;
      3'd4:    w_sizeMask = 4'b1111;
      default: w_sizeMask = 4'b0000;
    endcase
    w_mask8 = {4'b0000, w_sizeMask} << r_addr[1:0];
    case (r_addr[1:0])
      2'd0:    w_wdataRot = r_wdata;
      2'd1:    w_wdataRot = {r_wdata[23:0], r_wdata[31:24]};
      2'd2:    w_wdataRot = {r_wdata[15:0], r_wdata[31:16]};
      default: w_wdataRot = {r_wdata[7:0],  r_wdata[31:8]};
    endcase
  end

  // SRAM port: beat 0 uses the low lanes of the request word, beat 1 the wrapped lanes of the next word.
  always_comb begin
    w_sramEn   = (r_state == ACC0) || (r_state == ACC1);
    w_sramWe   = 4'b0000;
    w_sramAddr = r_addr[AW+1:2];
    if (r_state == ACC1) w_sramAddr = r_addr[AW+1:2] + AW'(1);
    if (r_write && (r_state == ACC0)) w_sramWe = w_mask8[3:0];
    if (r_write && (r_state == ACC1)) w_sramWe = w_mask8[7:4];
  end

  dmem_sram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk    (clk),
    .i_en   (w_sramEn),
    .i_we   (w_sramWe),
    .i_addr (w_sramAddr),
    .i_wdata(w_wdataRot),
    .o_rdata(w_sramRdata)
  );

  // Hold the first beat's read word while the second beat is fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_beat0 <= '0;
    else if (r_state == ACC1)  r_beat0 <= w_sramRdata;
  end

  // Little-endian reassembly across beats, shift by offset, then extend.
  always_comb begin
    w_lo = r_split ? r_beat0 : w_sramRdata;
    case (r_addr[1:0])
      2'd0:    w_raw = w_lo;
      2'd1:    w_raw = {w_sramRdata[7:0],  w_lo[31:8]};
      2'd2:    w_raw = {w_sramRdata[15:0], w_lo[31:16]};
      default: w_raw = {w_sramRdata[23:0], w_lo[31:24]};
    endcase
    case (r_funct3)
      F3_B:    w_ext = {{24{w_raw[7]}}, w_raw[7:0]};
      F3_H:    w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      F3_W:    w_ext = w_raw;
      F3_BU:   w_ext = {24'd0, w_raw[7:0]};
      F3_HU:   w_ext = {16'd0, w_raw[15:0]};
      default: w_ext = 32'd0;
    endcase
  end

  // Handshake and response outputs decoded from the state.
  always_comb begin
    o_req_ready = (r_state == IDLE);
    o_rsp_valid = (r_state == RESP);
    o_rsp_err   = (r_state == RESP) && r_err;
    o_rsp_rdata = 32'd0;
    if ((r_state == RESP) && !r_err && !r_write) o_rsp_rdata = w_ext;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's load/store interface.
- Accepts one load/store request at a time over a valid/ready handshake.
- Performs byte/half/word accesses against an internal word-organised, byte-lane-enabled SRAM, with programmable wait states. Misaligned accesses that cross a word boundary are split into two beats.
- Returns sign/zero-extended load data and an error flag. Replaces the single-cycle data memory once the core moves to a stalling multi-cycle memory path.

Parameters:
- DEPTH_WORDS, 256: SRAM size in 32-bit words; must be a power of 2.
- WAIT_CYCLES, 1: wait states inserted before the first access beat; range 0..7.
- MISALIGN_EN, 1: 1 = split boundary-crossing accesses; 0 = flag them as errors.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_addr  input  32  byte address.
- req_funct3  input  3  access size/extension, RV32I load/store encoding.
- req_write  input  1  1 = store, 0 = load.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  request rejected; valid only with rsp_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - SRAM contents are not cleared.
- States: IDLE, WAIT, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, funct3, write and wdata, then classify the request:
    - Error → RESP with err=1.
    - WAIT_CYCLES=0 → ACC0.
    - Otherwise → WAIT.
  - req_ready=0 in every other state.
- WAIT: count WAIT_CYCLES cycles, then go to ACC0.
- ACC0:
  - Access word addr[31:2] with the lane mask for the low part.
  - Split access → ACC1; otherwise → RESP.
- ACC1: access word addr[31:2]+1 with the remaining lanes starting at lane 0, then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rdata and err driven.
  - Then IDLE; req_ready rises in the following cycle.
  - There is no response back-pressure.
- Latency from the accept cycle T:
  - rsp_valid at T+2+WAIT_CYCLES, plus 1 when split.
  - Errors respond at T+1.
- Sizes:
  - Byte = 1, half = 2, word = 4 bytes.
  - Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: funct3 000 SB, 001 SH, 010 SW.
- Errors (no SRAM write, rdata=0):
  - Load funct3 011, 110 or 111.
  - Store funct3 greater than 010.
  - Any touched byte address ≥ DEPTH_WORDS*4, including the second beat.
  - Boundary crossing when MISALIGN_EN=0.
- Split rule: (addr[1:0] + size) > 4.
  - Aligned and non-crossing misaligned accesses (e.g. LH at offset 1) take one beat.
- SRAM timing:
  - Synchronous read; data is captured at the end of each ACCn cycle.
  - Writes commit on the ACCn clock edge using byte enables.
- Load assembly:
  - Bytes are concatenated little-endian across beats, shifted by addr[1:0], then sign- or zero-extended per funct3.
- Stores: wdata is rotated left by 8*addr[1:0]; beat 1 takes the wrapped upper bytes.
- Input changes while the block is busy are ignored; requests are latched only at accept.
- Reset mid-operation:
  - The block returns to IDLE immediately and no response is produced.
  - A write already committed in ACC0 persists; the ACC1 beat is dropped.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum.
  - Size-decode function (funct3 → byte count).
- Sub-module dmem_sram_bank:
  - DEPTH_WORDS×32 storage with 4 byte-write-enables.
  - Single port, synchronous read, no reset.
- The FSM, lane/rotate logic and extension logic stay in dmem_responder.

Test Plan:
1. Reset with rst_n=0 held for 3 cycles, then released → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
2. WAIT_CYCLES=1: SW 0xDEADBEEF to 0x10, then LW from 0x10 → each rsp_valid exactly 3 cycles after accept; LW rdata=0xDEADBEEF, err=0.
3. SB 0x80 to 0x21, then LB 0x21 → 0xFFFFFF80; LBU 0x21 → 0x00000080; LH 0x20 → 0xFFFF8000 (the byte at 0x20 was previously 0).
4. Memory preloaded with 0x44332211 at 0x0 and 0x88776655 at 0x4; LW from 0x3 → rdata=0x77665544, response 4 cycles after accept (split). With MISALIGN_EN=0 → err=1 at T+1 and memory unchanged.
5. DEPTH_WORDS=256: LW 0x400 and SH 0x3FF → err=1, rdata=0, and a subsequent LW 0x3FC shows no change. Load funct3=011 → err=1.
6. Assert rst_n during WAIT of a split SW to 0x2 → no rsp_valid, next cycle req_ready=1, and the following LW 0x0 and LW 0x4 show the prior contents unchanged.
